// File: rtl/cache_mem_responder_if.sv
// Bus bundle between a cache line's mem_* initiator port, the responder, and backing memory.
// The responder takes the slave view; the cache line plus backing memory take the master view.
interface cache_mem_responder_if #(
    parameter int ADDRBITS  = 32,
    parameter int DATABITS  = 32,
    parameter int DEPTHBITS = 3
);
    // cache line side
    logic [ADDRBITS-1:0]  mem_addr;
    logic [DATABITS-1:0]  mem_in;
    logic                 mem_wrreq;
    logic                 mem_rdreq;
    logic [DATABITS-1:0]  mem_out;
    logic                 mem_out_valid;
    logic                 cache_line_pause;
    // backing memory side
    logic [ADDRBITS-1:0]  bm_addr;
    logic [DATABITS-1:0]  bm_wdata;
    logic                 bm_we;
    logic                 bm_re;
    logic                 bm_ready;
    logic [DATABITS-1:0]  bm_rdata;
    logic                 bm_rdata_valid;
    // status
    logic [DEPTHBITS:0]   rd_outstanding;
    logic                 err;

    modport slave (
        input  mem_addr, mem_in, mem_wrreq, mem_rdreq,
               bm_ready, bm_rdata, bm_rdata_valid,
        output mem_out, mem_out_valid, cache_line_pause,
               bm_addr, bm_wdata, bm_we, bm_re,
               rd_outstanding, err
    );

    modport master (
        output mem_addr, mem_in, mem_wrreq, mem_rdreq,
               bm_ready, bm_rdata, bm_rdata_valid,
        input  mem_out, mem_out_valid, cache_line_pause,
               bm_addr, bm_wdata, bm_we, bm_re,
               rd_outstanding, err
    );
endinterface

// File: rtl/cache_mem_responder.sv
// In-order memory responder: request FIFO -> single issue register -> backing memory,
// read data returned through one register stage, registered pause before the FIFO fills.
module cache_mem_responder #(
    parameter int ADDRBITS     = 32,
    parameter int DATABITS     = 32,
    parameter int DEPTHBITS    = 3,
    parameter int PAUSE_MARGIN = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_mem_responder_if.slave bus
);
    localparam int CW    = DEPTHBITS + 1;
    localparam int DEPTH = 1 << DEPTHBITS;
    localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        PAUSE_TH = CW'(DEPTH - PAUSE_MARGIN);
    localparam logic [DEPTHBITS-1:0] PTR_ONE  = DEPTHBITS'(1);

    typedef struct packed {
        logic                we;
        logic [ADDRBITS-1:0] addr;
        logic [DATABITS-1:0] data;
    } req_t;

    typedef enum logic {IDLE, BUSY} iss_state_t;

    req_t                 fifo_q [DEPTH];
    logic [DEPTHBITS-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_next;
    req_t                 push_req, iss_q;
    iss_state_t           state, state_next;
    logic                 req_any, collide, fifo_empty;
    logic                 load, push, drop;
    logic                 rd_acc, rv_ok, rv_bad;
    logic [CW-1:0]        rd_out, rd_out_next;

    // ---------------- enqueue side ----------------
    always_comb begin
        req_any    = bus.mem_wrreq | bus.mem_rdreq;
        collide    = bus.mem_wrreq & bus.mem_rdreq;
        fifo_empty = (count == '0);
        // a pop on the same edge frees a slot, so a full FIFO can still accept
        push       = req_any && ((count != CNT_FULL) || load);
        drop       = req_any && !push;
        // on collision the write wins: we=1 carries the write data
        push_req   = '{we: bus.mem_wrreq, addr: bus.mem_addr, data: bus.mem_in};
    end

    always_comb begin
        count_next = count;
        if (push && !load)
            count_next = count + CNT_ONE;
        else if (!push && load)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= push_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            bus.cache_line_pause <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) rd_ptr <= rd_ptr + PTR_ONE;
            count                <= count_next;
            bus.cache_line_pause <= (count_next >= PAUSE_TH);
        end
    end

    // ---------------- issue register ----------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.bm_ready) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            iss_q <= '0;
        end else begin
            state <= state_next;
            if (load) iss_q <= fifo_q[rd_ptr];
        end
    end

    assign bus.bm_we    = (state == BUSY) &&  iss_q.we;
    assign bus.bm_re    = (state == BUSY) && !iss_q.we;
    assign bus.bm_addr  = iss_q.addr;
    assign bus.bm_wdata = iss_q.data;

    // ---------------- read tracking and return ----------------
    always_comb begin
        rd_acc = (state == BUSY) && !iss_q.we && bus.bm_ready;
        // data with nothing outstanding cannot belong to any request of ours
        rv_ok  = bus.bm_rdata_valid && (rd_out != '0);
        rv_bad = bus.bm_rdata_valid && (rd_out == '0);
        rd_out_next = rd_out;
        if (rd_acc && !rv_ok)
            rd_out_next = rd_out + CNT_ONE;
        else if (!rd_acc && rv_ok)
            rd_out_next = rd_out - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_out            <= '0;
            bus.mem_out       <= '0;
            bus.mem_out_valid <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            rd_out            <= rd_out_next;
            bus.mem_out_valid <= rv_ok;
            if (rv_ok) bus.mem_out <= bus.bm_rdata;
            if (collide || drop || rv_bad) bus.err <= 1'b1;
        end
    end

    assign bus.rd_outstanding = rd_out;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a cycle table for latency/collision, then
// hand-written sequences for fill, flush, pause threshold, overflow and reset.
module tb_cache_mem_responder;
    localparam int AB = 32, DB = 32, DBITS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_mem_responder_if #(.ADDRBITS(AB), .DATABITS(DB), .DEPTHBITS(DBITS)) bus ();

    cache_mem_responder #(.ADDRBITS(AB), .DATABITS(DB), .DEPTHBITS(DBITS), .PAUSE_MARGIN(3)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int passed = 0, total = 0;

    // backing-memory model: accepts on bm_ready, returns read data one cycle after acceptance
    logic        bm_auto = 1'b0;
    logic        m_rvalid = 1'b0, t_rvalid = 1'b0;
    logic [31:0] m_rdata = '0, t_rdata = '0;
    logic [31:0] mem [256];
    logic [63:0] wq [$];
    logic [31:0] rq [$];

    assign bus.bm_rdata_valid = bm_auto ? m_rvalid : t_rvalid;
    assign bus.bm_rdata       = bm_auto ? m_rdata  : t_rdata;

    initial begin : bm_model
        logic        pend;
        logic [31:0] pdata;
        forever begin
            @(negedge clk);
            pend = 1'b0; pdata = '0;
            if (reset_n && bus.bm_we && bus.bm_ready) begin
                wq.push_back({bus.bm_addr, bus.bm_wdata});
                mem[bus.bm_addr[9:2]] = bus.bm_wdata;
            end
            if (reset_n && bus.bm_re && bus.bm_ready) begin
                pend  = 1'b1;
                pdata = mem[bus.bm_addr[9:2]];
            end
            @(posedge clk); #1;
            m_rvalid = pend;
            m_rdata  = pdata;
        end
    end

    initial begin : ret_monitor
        forever begin
            @(negedge clk);
            if (bus.mem_out_valid === 1'b1) rq.push_back(bus.mem_out);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        bus.mem_wrreq = 1'b0; bus.mem_rdreq = 1'b0;
        bus.mem_addr  = '0;   bus.mem_in    = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_in();
        bus.bm_ready = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        step();
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    endtask

    // reads one word per cycle starting at base, respecting pause; bm_ready toggles if asked
    task automatic line_fill(input logic [31:0] base, input int n, input bit toggle, input int budget);
        int idx = 0, cyc = 0;
        while (rq.size() < n && cyc < budget) begin
            bus.bm_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (!bus.cache_line_pause && idx < n) begin
                bus.mem_rdreq = 1'b1; bus.mem_addr = base + 32'(idx * 4); idx++;
            end else bus.mem_rdreq = 1'b0;
            step(); cyc++;
        end
        idle_in();
        chk("fill_returned", 64'(rq.size()), 64'(n));
    endtask

    typedef struct {
        logic rd, wr; logic [31:0] addr, wdata; logic rdy, rv; logic [31:0] rdata;
        logic e_re, e_we; logic [31:0] e_addr, e_wdata; logic e_mov; logic [31:0] e_mo;
        logic [3:0] e_rdo; logic e_err;
    } vec_t;

    vec_t tbl [12];
    bit   saw_pause;
    int   cyc;

    initial begin
        idle_in();
        bus.bm_ready = 1'b0;
        #2;
        chk("rst_bm_re",  64'(bus.bm_re), 0);
        chk("rst_bm_we",  64'(bus.bm_we), 0);
        chk("rst_mov",    64'(bus.mem_out_valid), 0);
        chk("rst_pause",  64'(bus.cache_line_pause), 0);
        chk("rst_rdo",    64'(bus.rd_outstanding), 0);
        chk("rst_err",    64'(bus.err), 0);

        // ---- table: single read 0x100 (latency), rd&wr collision at 0x40, spurious data ----
        //            rd wr addr     wdata          rdy rv rdata          re we e_addr   e_wdata        mov mo            rdo err
        tbl[0]  = '{1, 0, 32'h100, 32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0};
        tbl[1]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'h0,         0, 0};
        tbl[2]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          1, 0, 32'h100, 32'h0,         0, 32'h0,         0, 0};
        tbl[3]  = '{0, 0, 32'h0,   32'h0,         1, 1, 32'hDEADBEEF,   0, 0, 32'h0,   32'h0,         0, 32'h0,         1, 0};
        tbl[4]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         1, 32'hDEADBEEF,  0, 0};
        tbl[5]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 0};
        tbl[6]  = '{1, 1, 32'h40,  32'h12345678,  1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 0};
        tbl[7]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 1};
        tbl[8]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 1, 32'h40,  32'h12345678,  0, 32'hDEADBEEF,  0, 1};
        tbl[9]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 1};
        tbl[10] = '{0, 0, 32'h0,   32'h0,         1, 1, 32'hBAD0BAD0,   0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 1};
        tbl[11] = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h0,          0, 0, 32'h0,   32'h0,         0, 32'hDEADBEEF,  0, 1};

        do_reset();
        bm_auto = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.mem_rdreq = tbl[i].rd;   bus.mem_wrreq = tbl[i].wr;
            bus.mem_addr  = tbl[i].addr; bus.mem_in    = tbl[i].wdata;
            bus.bm_ready  = tbl[i].rdy;  t_rvalid = tbl[i].rv; t_rdata = tbl[i].rdata;
            chk($sformatf("t%0d_bm_re", i),  64'(bus.bm_re), 64'(tbl[i].e_re));
            chk($sformatf("t%0d_bm_we", i),  64'(bus.bm_we), 64'(tbl[i].e_we));
            if (tbl[i].e_re || tbl[i].e_we)
                chk($sformatf("t%0d_bm_addr", i), 64'(bus.bm_addr), 64'(tbl[i].e_addr));
            if (tbl[i].e_we)
                chk($sformatf("t%0d_bm_wdata", i), 64'(bus.bm_wdata), 64'(tbl[i].e_wdata));
            chk($sformatf("t%0d_mov", i),   64'(bus.mem_out_valid), 64'(tbl[i].e_mov));
            chk($sformatf("t%0d_mo", i),    64'(bus.mem_out), 64'(tbl[i].e_mo));
            chk($sformatf("t%0d_rdo", i),   64'(bus.rd_outstanding), 64'(tbl[i].e_rdo));
            chk($sformatf("t%0d_err", i),   64'(bus.err), 64'(tbl[i].e_err));
            chk($sformatf("t%0d_pause", i), 64'(bus.cache_line_pause), 0);
            step();
        end
        idle_in(); t_rvalid = 1'b0;

        // ---- pause threshold: 6 reads with bm stalled, pause rises at count 5 ----
        do_reset(); init_mem(); rq.delete(); bm_auto = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            bus.bm_ready  = (c >= 7);
            bus.mem_rdreq = (c <= 5);
            bus.mem_addr  = 32'h200 + 32'(c * 4);
            chk($sformatf("pause_c%0d", c), 64'(bus.cache_line_pause), 64'((c == 6 || c == 7) ? 1 : 0));
            if (c == 8) chk("pause_rdo_c8", 64'(bus.rd_outstanding), 1);
            step();
        end
        idle_in(); bus.bm_ready = 1'b1;
        cyc = 0;
        while (rq.size() < 6 && cyc < 100) begin step(); cyc++; end
        chk("pause_returned", 64'(rq.size()), 6);
        for (int k = 0; k < 6; k++)
            if (k < rq.size()) chk($sformatf("pause_word%0d", k), 64'(rq[k]), 64'(32'hA500_0080 + 32'(k)));
        step();
        chk("pause_err", 64'(bus.err), 0);
        chk("pause_rdo_end", 64'(bus.rd_outstanding), 0);

        // ---- 32-word fill with bm_ready toggling ----
        do_reset(); init_mem(); rq.delete(); bm_auto = 1'b1;
        saw_pause = 1'b0;
        fork
            line_fill(32'h0, 32, 1'b1, 600);
            begin
                for (int w = 0; w < 600 && rq.size() < 32; w++) begin
                    @(negedge clk);
                    if (bus.cache_line_pause) saw_pause = 1'b1;
                end
            end
        join
        for (int k = 0; k < 32; k++)
            if (k < rq.size()) chk($sformatf("fill_word%0d", k), 64'(rq[k]), 64'(32'hA500_0000 + 32'(k)));
        chk("fill_saw_pause", 64'(saw_pause), 1);
        step();
        chk("fill_err", 64'(bus.err), 0);
        chk("fill_rdo_end", 64'(bus.rd_outstanding), 0);

        // ---- 32-word flush then refill of the same region ----
        do_reset(); init_mem(); rq.delete(); wq.delete(); bm_auto = 1'b1;
        bus.bm_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.mem_wrreq = 1'b1; bus.mem_addr = 32'(i * 4); bus.mem_in = 32'hC0DE_0000 + 32'(i);
            step();
        end
        idle_in();
        line_fill(32'h0, 32, 1'b0, 400);
        chk("flush_wr_count", 64'(wq.size()), 32);
        for (int i = 0; i < 32; i++)
            if (i < wq.size()) chk($sformatf("flush_wr%0d", i), wq[i], {32'(i * 4), 32'hC0DE_0000 + 32'(i)});
        for (int k = 0; k < 32; k++)
            if (k < rq.size()) chk($sformatf("flush_rd%0d", k), 64'(rq[k]), 64'(32'hC0DE_0000 + 32'(k)));
        chk("flush_err", 64'(bus.err), 0);

        // ---- overflow: 10 writes with bm stalled, 10th dropped; push+pop while full ----
        do_reset(); wq.delete(); bm_auto = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            bus.bm_ready  = (c >= 12);
            bus.mem_wrreq = (c <= 9) || (c == 12);
            bus.mem_addr  = 32'h300 + 32'(((c <= 9) ? c : 10) * 4);
            bus.mem_in    = 32'hD000_0000 + 32'((c <= 9) ? c : 10);
            if (c == 9)  chk("ovf_err_before", 64'(bus.err), 0);
            if (c == 10) chk("ovf_err_after", 64'(bus.err), 1);
            if (c == 10) chk("ovf_pause", 64'(bus.cache_line_pause), 1);
            if (c == 11) chk("ovf_we_held", 64'(bus.bm_we), 1);
            if (c == 11) chk("ovf_addr_held", 64'(bus.bm_addr), 64'h300);
            step();
        end
        idle_in(); bus.bm_ready = 1'b1;
        repeat (20) step();
        chk("ovf_wr_count", 64'(wq.size()), 10);
        for (int j = 0; j < 10; j++)
            if (j < wq.size())
                chk($sformatf("ovf_wr%0d", j), wq[j],
                    {32'h300 + 32'(((j < 9) ? j : 10) * 4), 32'hD000_0000 + 32'((j < 9) ? j : 10)});

        // ---- reset with 3 reads outstanding, then late data ----
        do_reset(); bm_auto = 1'b0; t_rvalid = 1'b0; bus.bm_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.mem_rdreq = (c <= 2);
            bus.mem_addr  = 32'h400 + 32'(c * 4);
            step();
        end
        idle_in();
        chk("rst3_rdo_before", 64'(bus.rd_outstanding), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst3_rdo",   64'(bus.rd_outstanding), 0);
        chk("rst3_bm_re", 64'(bus.bm_re), 0);
        chk("rst3_mov",   64'(bus.mem_out_valid), 0);
        chk("rst3_mo",    64'(bus.mem_out), 0);
        chk("rst3_err",   64'(bus.err), 0);
        @(posedge clk); @(negedge clk); reset_n = 1'b1;
        step();
        t_rvalid = 1'b1; t_rdata = 32'h5A5A_5A5A;
        step();
        t_rvalid = 1'b0;
        chk("late_mov", 64'(bus.mem_out_valid), 0);
        chk("late_mo",  64'(bus.mem_out), 0);
        chk("late_err", 64'(bus.err), 1);
        chk("late_rdo", 64'(bus.rd_outstanding), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
